// File: rtl/bus_pkg.sv
// Shared types and constants for the 8088 minimum-mode bus cycle initiator.
package bus_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned HADR_W = 12;

    localparam logic [DATA_W-1:0] RD_ABORT_DATA = 8'hFF;

    typedef enum logic [2:0] {
        TI = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        TW = 3'd4,
        T4 = 3'd5,
        TH = 3'd6
    } bus_state_e;

    typedef struct packed {
        logic              write;
        logic              io;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter: clears, increments, saturates at MAX_WAIT and flags expiry.
module bus_wait_timer
    import bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT   = 15,
    parameter int unsigned WAIT_CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired_c
);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    assign expired_c = (cnt_q == WAIT_CNT_W'(MAX_WAIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !expired_c) begin
            cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_cycle_initiator.sv
// Initiator side of the 8088 minimum-mode multiplexed bus: runs T1-T2-T3-(TW)-T4
// cycles for single-byte requests, with READY wait states, HOLD/HLDA and a watchdog.
module bus_cycle_initiator
    import bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT   = 15,
    parameter int unsigned WAIT_CNT_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_io,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    inout  wire  [DATA_W-1:0] AD,
    output logic [HADR_W-1:0] A,
    output logic              ALE,
    output logic              IOM,
    output logic              RD,
    output logic              WR,
    output logic              DTR,
    output logic              DEN,
    input  logic              READY,
    input  logic              HOLD,
    output logic              HLDA
);

    bus_state_e        state_q, state_d;
    bus_req_t          req_q, req_d;
    logic              ale_q, ale_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              den_n_q, den_n_d;
    logic              hlda_q, hlda_d;
    logic              ad_oe_q, ad_oe_d;
    logic [DATA_W-1:0] ad_out_q, ad_out_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic accept_c;
    logic sample_c;
    logic strobe_c;
    logic expired_c;

    bus_wait_timer #(
        .MAX_WAIT   (MAX_WAIT),
        .WAIT_CNT_W (WAIT_CNT_W)
    ) u_wait_timer (
        .clk       (CLK),
        .rst       (RESET),
        .clr       (state_q == T1),
        .inc       (sample_c && !READY),
        .expired_c (expired_c)
    );

    assign req_ready = (state_q == TI) && !HOLD && !RESET;
    assign accept_c  = req_valid && req_ready;
    assign sample_c  = (state_q == T3) || (state_q == TW);

    // Latched request supplies A/IOM/DTR, so they stay stable for the whole cycle.
    assign AD        = ad_oe_q ? ad_out_q : 'z;
    assign A         = req_q.addr[ADDR_W-1:DATA_W];
    assign IOM       = req_q.io;
    assign DTR       = req_q.write;
    assign ALE       = ale_q;
    assign RD        = rd_n_q;
    assign WR        = wr_n_q;
    assign DEN       = den_n_q;
    assign HLDA      = hlda_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;

        case (state_q)
            TI: begin
                if (HOLD) begin
                    state_d = TH;
                end else if (accept_c) begin
                    state_d       = T1;
                    req_d.write   = req_write;
                    req_d.io      = req_io;
                    req_d.addr    = req_io ? {4'h0, req_addr[15:0]} : req_addr;
                    req_d.wdata   = req_wdata;
                end
            end
            T1: state_d = T2;
            T2: state_d = T3;
            T3, TW: begin
                if (READY) begin
                    state_d = T4;
                    if (!req_q.write) begin
                        rsp_rdata_d = AD;
                    end
                end else if (expired_c) begin
                    state_d     = T4;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = RD_ABORT_DATA;
                end else begin
                    state_d = TW;
                end
            end
            T4: state_d = TI;
            TH: begin
                if (!HOLD) begin
                    state_d = TI;
                end
            end
            default: state_d = TI;
        endcase

        // Pin levels are decoded from the next state so they line up with it.
        strobe_c    = (state_d == T2) || (state_d == T3) || (state_d == TW);
        ale_d       = (state_d == T1);
        rd_n_d      = !(strobe_c && !req_d.write);
        wr_n_d      = !(strobe_c && req_d.write);
        den_n_d     = !strobe_c;
        ad_oe_d     = (state_d == T1) || (strobe_c && req_d.write);
        ad_out_d    = (state_d == T1) ? req_d.addr[DATA_W-1:0] : req_d.wdata;
        hlda_d      = (state_d == TH);
        rsp_valid_d = (state_d == T4);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= TI;
            req_q       <= '0;
            ale_q       <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            den_n_q     <= 1'b1;
            hlda_q      <= 1'b0;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ale_q       <= ale_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            den_n_q     <= den_n_d;
            hlda_q      <= hlda_d;
            ad_oe_q     <= ad_oe_d;
            ad_out_q    <= ad_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// Self-checking bench for bus_cycle_initiator with a randomized responder and cycle model.
module tb_bus_cycle_initiator;

    localparam int MAX_WAIT = 15;

    logic        CLK;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    tri1  [7:0]  AD;
    logic [11:0] A;
    logic        ALE, IOM, RD, WR, DTR, DEN;
    logic        READY;
    logic        HOLD;
    logic        HLDA;
    logic [7:0]  resp_data;

    int n_checks = 0;
    int n_fails  = 0;

    bus_cycle_initiator #(
        .MAX_WAIT   (15),
        .WAIT_CNT_W (4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_io    (req_io),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .AD        (AD),
        .A         (A),
        .ALE       (ALE),
        .IOM       (IOM),
        .RD        (RD),
        .WR        (WR),
        .DTR       (DTR),
        .DEN       (DEN),
        .READY     (READY),
        .HOLD      (HOLD),
        .HLDA      (HLDA)
    );

    // Responder drives read data whenever RD is asserted; floating bus reads as FF.
    assign AD = (RD == 1'b0) ? resp_data : 8'bz;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Runs one request and checks it against the cycle model derived from its parameters.
    task automatic run_cycle(input logic wr, input logic io, input logic [19:0] addr,
                             input logic [7:0] wdata, input logic [7:0] rdata,
                             input int n_wait, input bit hold_t2, input string name);
        int          guard;
        int          strobe;
        int          tw_exp;
        bit          exp_err;
        logic [19:0] exp_addr;
        logic        strobe_pin;
        logic        other_pin;

        exp_addr  = io ? {4'h0, addr[15:0]} : addr;
        tw_exp    = (n_wait > MAX_WAIT) ? MAX_WAIT : n_wait;
        exp_err   = (n_wait > MAX_WAIT);
        req_write = wr;
        req_io    = io;
        req_addr  = addr;
        req_wdata = wdata;
        resp_data = rdata;
        READY     = (n_wait == 0);
        req_valid = 1'b1;
        guard     = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            tick;
            guard++;
        end
        n_checks++;
        if (guard >= 50) begin
            $display("FAIL %s accept_timeout got req_ready=%b required 1", name, req_ready);
            n_fails++;
        end
        tick;
        req_valid = 1'b0;
        req_addr  = 20'($urandom);
        req_wdata = 8'($urandom);

        n_checks++;
        if ({ALE, A, AD, IOM, DTR, RD, WR, DEN} !== {1'b1, exp_addr, io, wr, 3'b111}) begin
            $display("FAIL %s t1_bus got=%h required=%h", name,
                     {ALE, A, AD, IOM, DTR, RD, WR, DEN}, {1'b1, exp_addr, io, wr, 3'b111});
            n_fails++;
        end

        tick;
        strobe     = 0;
        strobe_pin = wr ? WR : RD;
        while (strobe_pin === 1'b0 && strobe < 40) begin
            other_pin = wr ? RD : WR;
            n_checks++;
            if ({ALE, DEN, other_pin, A, IOM, DTR, rsp_valid} !==
                {1'b0, 1'b0, 1'b1, exp_addr[19:8], io, wr, 1'b0}) begin
                $display("FAIL %s strobe_phase%0d got=%h required=%h", name, strobe,
                         {ALE, DEN, other_pin, A, IOM, DTR, rsp_valid},
                         {1'b0, 1'b0, 1'b1, exp_addr[19:8], io, wr, 1'b0});
                n_fails++;
            end
            if (wr) begin
                n_checks++;
                if (AD !== wdata) begin
                    $display("FAIL %s write_data got=%h required=%h", name, AD, wdata);
                    n_fails++;
                end
            end
            if (hold_t2 && strobe == 0) HOLD = 1'b1;
            strobe++;
            READY = (strobe >= n_wait + 2);
            tick;
            strobe_pin = wr ? WR : RD;
        end

        n_checks++;
        if (strobe !== 2 + tw_exp) begin
            $display("FAIL %s strobe_clocks got=%0d required=%0d", name, strobe, 2 + tw_exp);
            n_fails++;
        end
        n_checks++;
        if ({rsp_valid, rsp_err, RD, WR, DEN, ALE} !== {1'b1, exp_err, 4'b1110}) begin
            $display("FAIL %s t4_pins got=%b required=%b", name,
                     {rsp_valid, rsp_err, RD, WR, DEN, ALE}, {1'b1, exp_err, 4'b1110});
            n_fails++;
        end
        n_checks++;
        if (AD !== 8'hFF) begin
            $display("FAIL %s t4_ad_float got=%h required=FF(float)", name, AD);
            n_fails++;
        end
        if (!wr || exp_err) begin
            n_checks++;
            if (rsp_rdata !== (exp_err ? 8'hFF : rdata)) begin
                $display("FAIL %s rsp_rdata got=%h required=%h", name, rsp_rdata,
                         exp_err ? 8'hFF : rdata);
                n_fails++;
            end
        end
        READY = 1'b1;
        tick;
        n_checks++;
        if ({rsp_valid, rsp_err, req_ready} !== {1'b0, 1'b0, !HOLD}) begin
            $display("FAIL %s after_t4 got=%b required=%b", name,
                     {rsp_valid, rsp_err, req_ready}, {1'b0, 1'b0, !HOLD});
            n_fails++;
        end
    endtask

    task automatic test_reset;
        RESET     = 1'b1;
        req_valid = 1'b1;
        repeat (3) tick;
        n_checks++;
        if ({ALE, RD, WR, DEN, DTR, IOM, A, HLDA, rsp_valid, rsp_err, rsp_rdata, req_ready} !==
            {1'b0, 3'b111, 2'b00, 12'h000, 1'b0, 2'b00, 8'h00, 1'b0}) begin
            $display("FAIL reset_state got=%h",
                     {ALE, RD, WR, DEN, DTR, IOM, A, HLDA, rsp_valid, rsp_err, rsp_rdata, req_ready});
            n_fails++;
        end
        n_checks++;
        if (AD !== 8'hFF) begin
            $display("FAIL reset_ad_float got=%h required=FF(float)", AD);
            n_fails++;
        end
        req_valid = 1'b0;
        RESET     = 1'b0;
        tick;
        n_checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL reset_release_ready got=%b required=1", req_ready);
            n_fails++;
        end
    endtask

    task automatic test_mem_read;
        run_cycle(1'b0, 1'b0, 20'h0_1234, 8'h00, 8'hA5, 0, 1'b0, "mem_read");
    endtask

    task automatic test_io_write;
        run_cycle(1'b1, 1'b1, 20'h0_FF0F, 8'h3C, 8'h00, 0, 1'b0, "io_write");
    endtask

    task automatic test_wait_states;
        run_cycle(1'b0, 1'b0, 20'hA_BC12, 8'h00, 8'h5A, 3, 1'b0, "wait3_read");
        run_cycle(1'b1, 1'b0, 20'h3_0F01, 8'h96, 8'h00, 15, 1'b0, "wait15_write");
    endtask

    task automatic test_watchdog;
        run_cycle(1'b0, 1'b0, 20'h7_0102, 8'h00, 8'h33, 1000, 1'b0, "watchdog_read");
        run_cycle(1'b0, 1'b1, 20'h9_0080, 8'h00, 8'h71, 0, 1'b0, "post_watchdog");
    endtask

    task automatic test_hold;
        run_cycle(1'b0, 1'b0, 20'h4_4321, 8'h00, 8'h19, 1, 1'b1, "hold_cycle");
        n_checks++;
        if ({HLDA, req_ready} !== 2'b00) begin
            $display("FAIL hold_ti got=%b required=00", {HLDA, req_ready});
            n_fails++;
        end
        req_write = 1'b1;
        req_io    = 1'b0;
        req_addr  = 20'h2_2468;
        req_wdata = 8'hC3;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if ({HLDA, req_ready, RD, WR, DEN, ALE, AD} !== {2'b10, 4'b1110, 8'hFF}) begin
                $display("FAIL hold_th%0d got=%h required=%h", i,
                         {HLDA, req_ready, RD, WR, DEN, ALE, AD}, {2'b10, 4'b1110, 8'hFF});
                n_fails++;
            end
        end
        HOLD = 1'b0;
        tick;
        n_checks++;
        if ({HLDA, req_ready} !== 2'b01) begin
            $display("FAIL hold_release got=%b required=01", {HLDA, req_ready});
            n_fails++;
        end
        run_cycle(1'b1, 1'b0, 20'h2_2468, 8'hC3, 8'h00, 0, 1'b0, "pending_after_hold");
    endtask

    task automatic test_reset_mid;
        int guard;
        req_write = 1'b1;
        req_io    = 1'b0;
        req_addr  = 20'h5_6789;
        req_wdata = 8'h81;
        READY     = 1'b0;
        req_valid = 1'b1;
        guard     = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            tick;
            guard++;
        end
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        n_checks++;
        if ({WR, DEN} !== 2'b00) begin
            $display("FAIL rstmid_t3 got=%b required=00", {WR, DEN});
            n_fails++;
        end
        RESET = 1'b1;
        tick;
        n_checks++;
        if ({WR, DEN, RD, ALE, rsp_valid, AD} !== {3'b111, 2'b00, 8'hFF}) begin
            $display("FAIL rstmid_abandon got=%h required=%h",
                     {WR, DEN, RD, ALE, rsp_valid, AD}, {3'b111, 2'b00, 8'hFF});
            n_fails++;
        end
        RESET = 1'b0;
        READY = 1'b1;
        tick;
        n_checks++;
        if ({rsp_valid, req_ready, ALE} !== 3'b010) begin
            $display("FAIL rstmid_idle got=%b required=010", {rsp_valid, req_ready, ALE});
            n_fails++;
        end
        run_cycle(1'b0, 1'b0, 20'hF_EDCB, 8'h00, 8'h6E, 2, 1'b0, "post_reset_read");
    endtask

    task automatic test_random;
        logic        wr;
        logic        io;
        logic [19:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        int          nw;
        for (int i = 0; i < 16; i++) begin
            wr   = 1'($urandom);
            io   = 1'($urandom);
            addr = 20'($urandom);
            wd   = 8'($urandom);
            rd   = 8'($urandom);
            nw   = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
            run_cycle(wr, io, addr, wd, rd, nw, 1'b0, "random");
        end
    endtask

    initial begin
        RESET     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_io    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        READY     = 1'b1;
        HOLD      = 1'b0;
        resp_data = '0;
        test_reset();
        test_mem_read();
        test_io_write();
        test_wait_states();
        test_watchdog();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
